// File: rtl/data_mem_bridge.sv
// Memory-stage bridge: turns core loads/stores into request/grant/response bus
// transactions, stalling the core until the bus completes or times out.
module data_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  storeSrc,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic [31:0] loadAddress,
  output logic        stall,
  output logic        misalignedFault,
  output logic        busError,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [3:0]  busBe,
  output logic [31:0] busWdata,
  input  logic        busGnt,
  input  logic        busRvalid,
  input  logic [31:0] busRdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] laddr_q, laddr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic        err_q, err_d;

  logic        aligned;
  logic [3:0]  be_st;
  logic [31:0] wd_st;
  logic        timeout;

  // Store lane steering; unknown funct3 encodings behave as sw.
  always_comb begin
    aligned = 1'b1;
    be_st   = 4'b1111;
    wd_st   = writeData;
    case (storeSrc)
      3'b000: begin
        be_st = 4'b0001 << address[1:0];
        wd_st = {4{writeData[7:0]}};
      end
      3'b001: begin
        aligned = ~address[0];
        be_st   = address[1] ? 4'b1100 : 4'b0011;
        wd_st   = {2{writeData[15:0]}};
      end
      default: aligned = (address[1:0] == 2'b00);
    endcase
  end

  assign timeout = (cnt_q == TO_LAST);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rdata_d         = rdata_q;
    laddr_d         = laddr_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    be_d            = be_q;
    we_d            = we_q;
    err_d           = 1'b0;
    stall           = 1'b0;
    misalignedFault = 1'b0;
    case (state_q)
      IDLE: begin
        if (memRead) begin
          stall   = 1'b1;
          addr_d  = {address[31:2], 2'b00};
          laddr_d = address;
          we_d    = 1'b0;
          be_d    = 4'b0000;
          wdata_d = '0;
          cnt_d   = '0;
          state_d = REQ;
        end else if (memWrite && aligned) begin
          stall   = 1'b1;
          addr_d  = {address[31:2], 2'b00};
          we_d    = 1'b1;
          be_d    = be_st;
          wdata_d = wd_st;
          cnt_d   = '0;
          state_d = REQ;
        end else if (memWrite) begin
          misalignedFault = 1'b1;
        end
      end
      REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + 16'd1;
        // A load grant on the last allowed cycle cannot complete in budget.
        if (busGnt && we_q) begin
          state_d = DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = DONE;
          if (!we_q) rdata_d = '0;
        end else if (busGnt) begin
          state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        stall = 1'b1;
        cnt_d = cnt_q + 16'd1;
        if (busRvalid) begin
          rdata_d = busRdata;
          state_d = DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      laddr_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      laddr_q <= laddr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign readData    = rdata_q;
  assign loadAddress = laddr_q;
  assign busError    = err_q;
  assign busReq      = (state_q == REQ);
  assign busWe       = we_q;
  assign busAddr     = addr_q;
  assign busBe       = be_q;
  assign busWdata    = wdata_q;

endmodule
